// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder: one 16-bit command per CS frame, answer shifted out in the next frame.
// Exposes channel words, peaks, an ID word and one writable 12-bit control register.
module spi_slave_regs #(
  parameter logic [15:0] ID_WORD  = 16'hA5C3,
  parameter logic [11:0] CTRL_RST = 12'h000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sclk_i,
  input  logic        cs_n_i,
  input  logic        simo_i,
  output logic        somi_o,
  output logic        somi_oe_o,
  input  logic [15:0] data0_i,
  input  logic [15:0] data1_i,
  input  logic [15:0] data2_i,
  input  logic [15:0] data3_i,
  input  logic [13:0] max1_i,
  input  logic [13:0] max2_i,
  output logic [11:0] ctrl_o,
  output logic        wr_strobe_o,
  output logic        frame_err_o
);

  // [0],[1] synchronizer, [2] edge-detect history
  logic [2:0]  sclk_q, sclk_d;
  logic [2:0]  cs_q, cs_d;
  logic [1:0]  simo_q, simo_d;
  logic [1:0]  fill_q, fill_d;
  logic        armed_q, armed_d;
  logic        active_q, active_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] shadow_q, shadow_d;
  logic        somi_q, somi_d;
  logic [11:0] ctrl_q, ctrl_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic        frame_err_q, frame_err_d;

  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic        cmd_wr6;
  logic [11:0] ctrl_post;
  logic [15:0] rd_val;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];

  assign cmd_wr6   = rx_q[15] & (rx_q[14:12] == 3'd6);
  // A read-back after a write to ctrl returns the value just written
  assign ctrl_post = cmd_wr6 ? rx_q[11:0] : ctrl_q;

  always_comb begin
    case (rx_q[14:12])
      3'd0:    rd_val = data0_i;
      3'd1:    rd_val = data1_i;
      3'd2:    rd_val = data2_i;
      3'd3:    rd_val = data3_i;
      3'd4:    rd_val = {2'b00, max1_i};
      3'd5:    rd_val = {2'b00, max2_i};
      3'd6:    rd_val = {4'h0, ctrl_post};
      default: rd_val = ID_WORD;
    endcase
  end

  always_comb begin
    sclk_d      = {sclk_q[1:0], sclk_i};
    cs_d        = {cs_q[1:0], cs_n_i};
    simo_d      = {simo_q[0], simo_i};
    fill_d      = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    // Only a cs_n high sampled after reset (not the reset value) arms frame detection
    armed_d     = armed_q | ((fill_q == 2'd2) & cs_q[1]);
    active_d    = active_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    shadow_d    = shadow_q;
    somi_d      = somi_q;
    ctrl_d      = ctrl_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    if (active_q) begin
      if (sclk_rise) begin
        rx_d = {rx_q[14:0], simo_q[1]};
        if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
      end
      if (sclk_fall) begin
        tx_d   = {tx_q[14:0], 1'b0};
        somi_d = tx_q[14];
      end
      if (cs_rise) begin
        active_d = 1'b0;
        somi_d   = 1'b0;
        if (cnt_q == 5'd16) begin
          if (cmd_wr6) begin
            ctrl_d      = rx_q[11:0];
            wr_strobe_d = 1'b1;
          end
          shadow_d = rd_val;
        end else begin
          frame_err_d = 1'b1;
          shadow_d    = 16'h0000;
        end
      end
    end else if (armed_q && cs_fall) begin
      active_d = 1'b1;
      cnt_d    = 5'd0;
      tx_d     = shadow_q;
      somi_d   = shadow_q[15];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q      <= 3'b000;
      cs_q        <= 3'b111;
      simo_q      <= 2'b00;
      fill_q      <= 2'd0;
      armed_q     <= 1'b0;
      active_q    <= 1'b0;
      cnt_q       <= 5'd0;
      rx_q        <= 16'h0000;
      tx_q        <= 16'h0000;
      shadow_q    <= 16'h0000;
      somi_q      <= 1'b0;
      ctrl_q      <= CTRL_RST;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      simo_q      <= simo_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      shadow_q    <= shadow_d;
      somi_q      <= somi_d;
      ctrl_q      <= ctrl_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign somi_o      = somi_q;
  assign somi_oe_o   = active_q;
  assign ctrl_o      = ctrl_q;
  assign wr_strobe_o = wr_strobe_q;
  assign frame_err_o = frame_err_q;

endmodule
